// File: rtl/shader_fetch_unit.sv
// Instruction fetch/issue stage: 16-entry program memory, sequencer and valid/ready
// issue register with a one-cycle bubble on read-after-write hazards.
module shader_fetch_unit #(
  parameter int DEPTH              = 16,
  parameter int INSTR_W            = 16,
  parameter bit STALL_CLR_ON_START = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [INSTR_W-1:0]       load_data,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     issue_valid,
  input  logic                     issue_ready,
  output logic [1:0]               op,
  output logic [3:0]               mask,
  output logic [2:0]               dest,
  output logic [2:0]               srcA,
  output logic [2:0]               srcB,
  output logic [$clog2(DEPTH)-1:0] issue_pc,
  output logic [7:0]               stall_cnt
);
  localparam int PC_W = $clog2(DEPTH);
  localparam logic [PC_W-1:0] LAST_PC = PC_W'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t state_reg, state_next;
  logic [INSTR_W-1:0] imem [DEPTH];

  logic [PC_W-1:0] pc_reg, pc_next;
  logic [PC_W-1:0] issue_pc_reg, issue_pc_next;
  logic            issue_valid_reg, issue_valid_next;
  logic [1:0]      op_reg, op_next;
  logic [3:0]      mask_reg, mask_next;
  logic [2:0]      dest_reg, dest_next;
  logic [2:0]      srca_reg, srca_next;
  logic [2:0]      srcb_reg, srcb_next;
  logic [7:0]      stall_cnt_reg, stall_cnt_next;
  logic            fetched_all_reg, fetched_all_next;

  logic [PC_W-1:0]    fetch_pc;
  logic [INSTR_W-1:0] cand_word;
  logic               handoff;
  logic               can_fetch;
  logic               hazard;
  logic               take;
  logic [1:0]         src_hit;

  always_ff @(posedge clk) begin
    if (state_reg == S_IDLE && load_en) begin
      imem[load_addr] <= load_data;
    end
  end

  // A start edge fetches entry 0 directly; a same-edge write to entry 0 is forwarded.
  assign fetch_pc  = (state_reg == S_IDLE) ? '0 : pc_reg;
  assign cand_word = (state_reg == S_IDLE && load_en && load_addr == fetch_pc)
                     ? load_data : imem[fetch_pc];

  assign handoff   = issue_valid_reg & issue_ready;
  assign can_fetch = ~issue_valid_reg | issue_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src_cmp
      assign src_hit[gi] = (cand_word[3*gi +: 3] == dest_reg);
    end
  endgenerate

  // After a bubble the issue register is empty, so the retried candidate is never checked.
  assign hazard = handoff && (mask_reg != 4'd0) && (|src_hit);

  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    issue_pc_next    = issue_pc_reg;
    issue_valid_next = issue_valid_reg;
    op_next          = op_reg;
    mask_next        = mask_reg;
    dest_next        = dest_reg;
    srca_next        = srca_reg;
    srcb_next        = srcb_reg;
    stall_cnt_next   = stall_cnt_reg;
    fetched_all_next = fetched_all_reg;
    take             = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          if (STALL_CLR_ON_START) begin
            stall_cnt_next = '0;
          end
          fetched_all_next = 1'b0;
          pc_next          = '0;
          if (cand_word[15]) begin
            state_next = S_DONE;
          end else begin
            take       = 1'b1;
            state_next = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (can_fetch) begin
          if (fetched_all_reg || cand_word[15]) begin
            issue_valid_next = 1'b0;
            state_next       = S_DONE;
          end else if (hazard) begin
            issue_valid_next = 1'b0;
            if (stall_cnt_reg != 8'hFF) begin
              stall_cnt_next = stall_cnt_reg + 8'd1;
            end
          end else begin
            take = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
        pc_next    = '0;
      end
      default: state_next = S_IDLE;
    endcase

    if (take) begin
      op_next          = cand_word[14:13];
      mask_next        = cand_word[12:9];
      dest_next        = cand_word[8:6];
      srca_next        = cand_word[5:3];
      srcb_next        = cand_word[2:0];
      issue_pc_next    = fetch_pc;
      issue_valid_next = 1'b1;
      // The last entry parks pc; its handoff then ends the program.
      if (fetch_pc == LAST_PC) begin
        fetched_all_next = 1'b1;
      end else begin
        pc_next = fetch_pc + PC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      pc_reg          <= '0;
      issue_pc_reg    <= '0;
      issue_valid_reg <= 1'b0;
      op_reg          <= '0;
      mask_reg        <= '0;
      dest_reg        <= '0;
      srca_reg        <= '0;
      srcb_reg        <= '0;
      stall_cnt_reg   <= '0;
      fetched_all_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      issue_pc_reg    <= issue_pc_next;
      issue_valid_reg <= issue_valid_next;
      op_reg          <= op_next;
      mask_reg        <= mask_next;
      dest_reg        <= dest_next;
      srca_reg        <= srca_next;
      srcb_reg        <= srcb_next;
      stall_cnt_reg   <= stall_cnt_next;
      fetched_all_reg <= fetched_all_next;
    end
  end

  assign busy        = (state_reg == S_RUN);
  assign done        = (state_reg == S_DONE);
  assign issue_valid = issue_valid_reg;
  assign op          = op_reg;
  assign mask        = mask_reg;
  assign dest        = dest_reg;
  assign srcA        = srca_reg;
  assign srcB        = srcb_reg;
  assign issue_pc    = issue_pc_reg;
  assign stall_cnt   = stall_cnt_reg;

endmodule

// File: tb/tb_shader_fetch_unit.sv
// Scoreboard bench for shader_fetch_unit: directed programs push expected issues and
// done pulses; a negedge monitor pops and compares them on every handoff / done.
module tb_shader_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_en = 1'b0;
  logic [3:0]  load_addr = '0;
  logic [15:0] load_data = '0;
  logic        start = 1'b0;
  logic        issue_ready = 1'b1;

  logic        busy, done, issue_valid;
  logic [1:0]  op;
  logic [3:0]  mask;
  logic [2:0]  dest, srcA, srcB;
  logic [3:0]  issue_pc;
  logic [7:0]  stall_cnt;

  logic        s_busy, s_done, s_issue_valid;
  logic [1:0]  s_op;
  logic [3:0]  s_mask;
  logic [2:0]  s_dest, s_srcA, s_srcB;
  logic [3:0]  s_issue_pc;
  logic [7:0]  s_stall_cnt;

  always #5 clk = ~clk;

  shader_fetch_unit u_dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .start(start), .busy(busy), .done(done), .issue_valid(issue_valid),
    .issue_ready(issue_ready), .op(op), .mask(mask), .dest(dest), .srcA(srcA), .srcB(srcB),
    .issue_pc(issue_pc), .stall_cnt(stall_cnt)
  );

  // Same stimulus, stall counter never cleared by start: exercises saturation.
  shader_fetch_unit #(.STALL_CLR_ON_START(1'b0)) u_sat (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .start(start), .busy(s_busy), .done(s_done), .issue_valid(s_issue_valid),
    .issue_ready(issue_ready), .op(s_op), .mask(s_mask), .dest(s_dest), .srcA(s_srcA),
    .srcB(s_srcB), .issue_pc(s_issue_pc), .stall_cnt(s_stall_cnt)
  );

  typedef struct {
    int          cyc;
    logic [3:0]  pc;
    logic [15:0] word;
  } iss_t;

  typedef struct {
    int         cyc;
    logic [7:0] stall;
  } don_t;

  iss_t        iss_q[$];
  don_t        don_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          base = 0;
  logic [15:0] prog [16];

  function automatic logic [15:0] mk(input logic h, input logic [1:0] o, input logic [3:0] m,
                                     input logic [2:0] d, input logic [2:0] a,
                                     input logic [2:0] b);
    return {h, o, m, d, a, b};
  endfunction

  // Monitor: cycle numbers are relative to the start edge (+1 = cycle after it).
  always @(negedge clk) begin : mon
    iss_t        ei;
    don_t        ed;
    logic [15:0] got;
    logic        prev_hold;
    logic [19:0] prev_vec;
    cyc++;
    got = {1'b0, op, mask, dest, srcA, srcB};
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        checks++;
        if ({got, issue_pc} != prev_vec || !issue_valid) begin
          failures++;
          $display("FAIL hold_stable: got word=%h pc=%0d valid=%0b required word/pc=%h valid=1",
                   got, issue_pc, issue_valid, prev_vec);
        end
      end
      prev_hold = issue_valid && !issue_ready;
      prev_vec  = {got, issue_pc};

      if (issue_valid && issue_ready) begin
        checks++;
        if (iss_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_issue: got pc=%0d word=%h at +%0d required no issue",
                   issue_pc, got, cyc - base);
        end else begin
          ei = iss_q.pop_front();
          if (got != {1'b0, ei.word[14:0]} || issue_pc != ei.pc || (cyc - base) != ei.cyc) begin
            failures++;
            $display("FAIL issue: got pc=%0d word=%h at +%0d required pc=%0d word=%h at +%0d",
                     issue_pc, got, cyc - base, ei.pc, {1'b0, ei.word[14:0]}, ei.cyc);
          end else begin
            $display("issue pc=%0d word=%h at +%0d ok", issue_pc, got, cyc - base);
          end
        end
      end

      if (done) begin
        checks++;
        if (don_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_done: got done at +%0d required no done", cyc - base);
        end else begin
          ed = don_q.pop_front();
          if ((cyc - base) != ed.cyc || stall_cnt != ed.stall || busy || issue_valid) begin
            failures++;
            $display("FAIL done: got +%0d stall=%0d busy=%0b valid=%0b required +%0d stall=%0d busy=0 valid=0",
                     cyc - base, stall_cnt, busy, issue_valid, ed.cyc, ed.stall);
          end else begin
            $display("done at +%0d stall_cnt=%0d ok", cyc - base, stall_cnt);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_prog(input int n);
    for (int i = 0; i < n; i++) begin
      load_en   = 1'b1;
      load_addr = i[3:0];
      load_data = prog[i];
      tick();
    end
    load_en = 1'b0;
  endtask

  task automatic push_issue(input int c, input int p);
    iss_t e;
    e.cyc  = c;
    e.pc   = p[3:0];
    e.word = prog[p];
    iss_q.push_back(e);
  endtask

  task automatic push_done(input int c, input int s);
    don_t e;
    e.cyc   = c;
    e.stall = s[7:0];
    don_q.push_back(e);
  endtask

  task automatic chk_reset(input string name);
    checks++;
    if ({busy, done, issue_valid, op, mask, dest, srcA, srcB, issue_pc, stall_cnt} != '0) begin
      failures++;
      $display("FAIL %s: got busy=%0b done=%0b valid=%0b fields=%h pc=%0d stall=%0d required all 0",
               name, busy, done, issue_valid, {op, mask, dest, srcA, srcB}, issue_pc, stall_cnt);
    end
  endtask

  // bp: issue_ready low for cycles +1..+bp; poke: load_en+start during cycle +1;
  // rst_at: assert rst during that cycle and abandon the run.
  task automatic run(input int bp, input bit poke, input int rst_at, input bit exp_busy);
    start = 1'b1;
    @(posedge clk);
    base = cyc;
    #1;
    start = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      issue_ready = (k > bp);
      load_en     = poke && (k == 1);
      start       = poke && (k == 1);
      load_addr   = 4'd1;
      load_data   = 16'h7FFF;
      if (k == 1) begin
        checks++;
        if (busy != exp_busy) begin
          failures++;
          $display("FAIL busy_after_start: got %0b required %0b", busy, exp_busy);
        end
      end
      if (k == rst_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        iss_q.delete();
        don_q.delete();
        return;
      end
      if (k > 1 && iss_q.size() == 0 && don_q.size() == 0) begin
        issue_ready = 1'b1;
        return;
      end
      if (k == 200) begin
        checks++;
        failures++;
        $display("FAIL run_timeout: got %0d issues/%0d dones pending required 0",
                 iss_q.size(), don_q.size());
        iss_q.delete();
        don_q.delete();
        issue_ready = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic prog_basic();
    prog[0] = mk(1'b0, 2'd1, 4'hF, 3'd2, 3'd0, 3'd1);
    prog[1] = mk(1'b0, 2'd0, 4'hF, 3'd3, 3'd4, 3'd5);
    prog[2] = 16'h8000;
    load_prog(3);
  endtask

  initial begin
    int sat_exp;
    repeat (3) tick();
    chk_reset("reset_state");
    rst = 1'b0;
    tick();

    // Basic: two issues then HALT.
    prog_basic();
    push_issue(1, 0); push_issue(2, 1); push_done(3, 0);
    run(0, 1'b0, 0, 1'b1);

    // Hazard on srcA.
    prog[1] = mk(1'b0, 2'd0, 4'hF, 3'd3, 3'd2, 3'd5);
    load_prog(3);
    push_issue(1, 0); push_issue(3, 1); push_done(4, 1);
    run(0, 1'b0, 0, 1'b1);

    // Producer mask 0: no hazard.
    prog[0] = mk(1'b0, 2'd1, 4'h0, 3'd2, 3'd0, 3'd1);
    load_prog(3);
    push_issue(1, 0); push_issue(2, 1); push_done(3, 0);
    run(0, 1'b0, 0, 1'b1);

    // Backpressure for 3 cycles after the first issue.
    prog_basic();
    push_issue(4, 0); push_issue(5, 1); push_done(6, 0);
    run(3, 1'b0, 0, 1'b1);

    // load_en and start during RUN are ignored, and imem is unchanged afterwards.
    push_issue(1, 0); push_issue(2, 1); push_done(3, 0);
    run(0, 1'b1, 0, 1'b1);
    push_issue(1, 0); push_issue(2, 1); push_done(3, 0);
    run(0, 1'b0, 0, 1'b1);

    // HALT at entry 0.
    prog[0] = 16'h8000;
    load_prog(1);
    push_done(1, 0);
    run(0, 1'b0, 0, 1'b0);

    // 16 entries, no HALT, no hazards.
    for (int k = 0; k < 16; k++) begin
      prog[k] = mk(1'b0, k[1:0], k[3:0], 3'd7, 3'(k % 7), 3'((k + 3) % 7));
    end
    load_prog(16);
    for (int k = 0; k < 16; k++) push_issue(k + 1, k);
    push_done(17, 0);
    run(0, 1'b0, 0, 1'b1);

    // Reset while issue_pc=5 is presented.
    for (int k = 0; k < 5; k++) push_issue(k + 1, k);
    run(0, 1'b0, 6, 1'b1);
    @(negedge clk);
    chk_reset("mid_run_reset");
    checks++;
    if (s_stall_cnt != 8'd0 || s_busy) begin
      failures++;
      $display("FAIL sat_reset: got stall=%0d busy=%0b required 0/0", s_stall_cnt, s_busy);
    end
    repeat (4) tick();

    // Hazard chain: 15 bubbles per run; u_sat accumulates and saturates.
    for (int k = 0; k < 16; k++) begin
      prog[k] = mk(1'b0, 2'd3, 4'hF, 3'(k % 8), 3'((k + 7) % 8), 3'((k + 7) % 8));
    end
    load_prog(16);
    for (int r = 1; r <= 18; r++) begin
      for (int k = 0; k < 16; k++) push_issue(2 * k + 1, k);
      push_done(32, 15);
      run(0, 1'b0, 0, 1'b1);
      sat_exp = (15 * r > 255) ? 255 : 15 * r;
      checks++;
      if (s_stall_cnt != sat_exp[7:0]) begin
        failures++;
        $display("FAIL sat_stall_cnt: got %0d required %0d after run %0d", s_stall_cnt, sat_exp, r);
      end else begin
        $display("sat run %0d stall_cnt=%0d ok", r, s_stall_cnt);
      end
    end

    repeat (3) tick();
    checks++;
    if (iss_q.size() != 0 || don_q.size() != 0) begin
      failures++;
      $display("FAIL queues_drained: got %0d/%0d required 0/0", iss_q.size(), don_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shader_fetch_unit.md
# shader_fetch_unit

Instruction fetch and issue stage that sits directly upstream of the shader pipeline's register-file/ALU stage. It holds a 16-entry program memory that is written through a load port, and on `start` sequences through it. It presents decoded instruction fields to the execute stage over a valid/ready handshake. Because the execute stage writes results back one cycle late, the unit inserts a one-cycle bubble on read-after-write hazards. It stops on a HALT instruction or after entry 15.

## Interface
- `DEPTH`, 16: program memory entries (pc width = 4).
- `INSTR_W`, 16: instruction width. Fields: [15] HALT, [14:13] op, [12:9] mask, [8:6] dest, [5:3] srcA, [2:0] srcB.
- `clk`  in  1  clock, all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `load_en`  in  1  write `load_data` into imem[`load_addr`]; honoured only in IDLE.
- `load_addr`  in  4  program memory write address.
- `load_data`  in  16  instruction word to write.
- `start`  in  1  begin execution at pc 0; honoured only in IDLE.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse when the program finishes.
- `issue_valid`  out  1  issue register holds a valid instruction.
- `issue_ready`  in  1  execute stage accepts; transfer when `issue_valid & issue_ready`.
- `op`  out  2  issued ALU op.
- `mask`  out  4  issued lane mask.
- `dest`  out  3  issued destination register.
- `srcA`  out  3  issued source A.
- `srcB`  out  3  issued source B.
- `issue_pc`  out  4  imem index of the issued instruction.
- `stall_cnt`  out  8  hazard bubbles inserted since last `start`; saturates at 255.

## Operation
- States: IDLE, RUN, DONE.
- Reset: state IDLE, pc 0, `issue_valid` 0, `busy` 0, `done` 0, `stall_cnt` 0, field outputs 0, `issue_pc` 0. Imem contents are not reset.
- IDLE:
  - `load_en` writes imem.
  - `start` clears `stall_cnt`, sets pc 0 and enters RUN.
  - On that same edge, imem[0] is presented as the candidate (see fetch rule).
  - `load_en` and `start` together: the write happens first, and the fetch sees the new word.
- RUN, fetch rule: a candidate imem[pc] is considered on an edge where the issue register is empty or is handing off (`!issue_valid | issue_ready`).
  - Candidate HALT=1: not issued. `issue_valid` <= 0, go to DONE.
  - Hazard: the candidate's srcA or srcB equals `dest` of the instruction handed off on this same edge, and that instruction's mask != 0.
    - `issue_valid` <= 0 (bubble) and `stall_cnt` += 1 (saturating); pc is unchanged.
    - On the next edge the candidate loads with no hazard check.
  - Otherwise: the fields load into the issue register, `issue_pc` <= pc, `issue_valid` <= 1, pc += 1.
  - End of memory: after entry 15 hands off with no HALT, go to DONE. Pc does not wrap.
- Issue register: while `issue_valid & !issue_ready`, all field outputs and `issue_valid` hold stable.
- DONE: `done` is high for exactly one cycle, then the unit returns to IDLE. `busy` is 0.
- In RUN and DONE, `load_en` and `start` are ignored.
- `rst` mid-run aborts immediately to the reset values, with no `done` pulse.

## Timing
- `start` sampled at edge E0 gives `issue_valid`=1 with imem[0] in the cycle after E0, provided imem[0] is not HALT.
- If imem[0] is HALT: `done`=1 in the cycle after E0, and no issue occurs.
- Steady state with `issue_ready`=1 and no hazards: one instruction per cycle.
- A hazard costs exactly one cycle of `issue_valid`=0.
- The last handoff at edge En gives `done`=1 in the cycle after En, with `issue_valid`=0 in that cycle.
- `busy` rises in the cycle after the `start` edge and falls in the same cycle `done` rises.

## Test plan
- Load, then start, on this program:
  - imem[0] = op1, mask F, d2, a0, b1.
  - imem[1] = op0, mask F, d3, a4, b5.
  - imem[2] = HALT.
  - Expected, with `issue_ready`=1: issue at cycles +1 and +2 with `issue_pc` 0,1; `done` at +3; `stall_cnt`=0.
- Hazard: imem[1] srcA=2 after imem[0] dest=2, mask F. Expected: bubble at +2, imem[1] issues at +3, `stall_cnt`=1.
  - Repeat with imem[0] mask=0: expected no bubble.
- Backpressure: hold `issue_ready`=0 for 3 cycles after the first issue. Expected: fields and `issue_pc`=0 stable, pc not advancing; the sequence resumes unchanged.
- No HALT, all 16 entries non-hazardous. Expected: `issue_pc` 0..15, `done` one cycle after the last handoff, pc does not wrap.
- Robustness, three directed checks:
  - `load_en` during RUN: imem unchanged on the next run.
  - `start` during RUN: ignored.
  - `rst` asserted mid-run at pc 5: all outputs return to reset values next cycle, with no `done` pulse.
- Saturation: a 16-entry chain with 15 hazards, restarted repeatedly without reset. `stall_cnt` clears on each start and reads 15 each time.
  - Force more than 255 hazards via a long backpressure-free loop of restarts without `start` clearing (disable check). `stall_cnt` holds at 255.
